// File: rtl/apb_master_ctrl.sv
// APB requester: takes single read/write commands on a valid/ready port, runs
// SETUP/ACCESS on the APB bus and returns a one-cycle response with a watchdog abort.
module apb_master_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [STRB_WIDTH-1:0] req_strobe,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  sel,
    output logic                  enable,
    output logic                  write,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [STRB_WIDTH-1:0] strobe,
    input  logic                  ready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic                  slverr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       timeout_hit;
    logic       done;
    logic       accept;

    // A transfer ends either on ready or when the watchdog expires; ready wins a tie.
    assign timeout_hit = (state == ACCESS) && !ready && (cnt == CNT_LAST);
    assign done        = (state == ACCESS) && (ready || timeout_hit);
    assign req_ready   = (state == IDLE) || done;
    assign accept      = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            sel         <= 1'b0;
            enable      <= 1'b0;
            write       <= 1'b0;
            addr        <= '0;
            wdata       <= '0;
            strobe      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            if (done) begin
                rsp_valid   <= 1'b1;
                rsp_err     <= !ready || slverr;
                rsp_timeout <= !ready;
                rsp_rdata   <= (ready && !write && !slverr) ? rdata : '0;
            end

            // A new command can only be accepted in IDLE or on the completing cycle,
            // so it always takes precedence over the return to IDLE.
            if (accept) begin
                state  <= SETUP;
                cnt    <= '0;
                sel    <= 1'b1;
                enable <= 1'b0;
                write  <= req_write;
                addr   <= req_addr;
                wdata  <= req_wdata;
                strobe <= req_strobe;
            end else if (done) begin
                state  <= IDLE;
                cnt    <= '0;
                sel    <= 1'b0;
                enable <= 1'b0;
                write  <= 1'b0;
                addr   <= '0;
                wdata  <= '0;
                strobe <= '0;
            end else begin
                case (state)
                    SETUP: begin
                        state  <= ACCESS;
                        enable <= 1'b1;
                    end
                    ACCESS:  cnt <= cnt + 8'd1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: directed vector table plus random transfers, checked
// against transfer-level expectations (wait cycles -> access count / timeout / data).
module tb_apb_master_ctrl;
    localparam int AW = 32, DW = 32, SW = 4, TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [SW-1:0] req_strobe;
    logic          rsp_valid, rsp_err, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic          sel, enable, write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strobe;
    logic          ready, slverr;
    logic [DW-1:0] rdata;

    always #5 clk = ~clk;

    apb_master_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strobe(req_strobe),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .sel(sel), .enable(enable), .write(write), .addr(addr), .wdata(wdata), .strobe(strobe),
        .ready(ready), .rdata(rdata), .slverr(slverr)
    );

    // w = ACCESS cycles the slave stalls before ready (w >= TO means it never answers in time)
    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          w;
        bit          err;
        logic [31:0] rd;
        bit          chain;
        logic [31:0] e_rdata;
        bit          e_err;
        bit          e_to;
        int          e_acc;
    } vec_t;

    vec_t cq[$], aq[$], eq[$];
    vec_t cur;
    vec_t tbl[10];
    int   acc;
    bit   busy;
    int   tests = 0, fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit wr, logic [31:0] a, logic [31:0] d, logic [3:0] s, int w,
                                bit err, logic [31:0] rd, bit chain,
                                logic [31:0] e_rdata, bit e_err, bit e_to, int e_acc);
        vec_t v;
        v.wr = wr; v.addr = a; v.wdata = d; v.strb = s; v.w = w; v.err = err; v.rd = rd;
        v.chain = chain; v.e_rdata = e_rdata; v.e_err = e_err; v.e_to = e_to; v.e_acc = e_acc;
        return v;
    endfunction

    function automatic vec_t model(vec_t v);
        bit to;
        to = (v.w >= TO);
        v.e_to    = to;
        v.e_err   = to || v.err;
        v.e_rdata = (!to && !v.wr && !v.err) ? v.rd : 32'h0;
        v.e_acc   = to ? TO : v.w + 1;
        return v;
    endfunction

    task automatic check_fields(input string tag);
        chk({tag, "_addr"}, addr, cur.addr);
        chk({tag, "_wdata"}, wdata, cur.wdata);
        chk({tag, "_wr_strb"}, {27'h0, write, strobe}, {27'h0, cur.wr, cur.strb});
    endtask

    // One clock: observe outputs from the last edge, drive slave + requester, advance.
    task automatic cycle();
        bit hs;
        vec_t e;
        if (rsp_valid) begin
            if (eq.size() == 0) chk("rsp_unexpected", 1, 0);
            else begin
                e = eq.pop_front();
                chk("rsp_rdata", rsp_rdata, e.e_rdata);
                chk("rsp_err", rsp_err, e.e_err);
                chk("rsp_timeout", rsp_timeout, e.e_to);
                chk("access_cycles", acc, e.e_acc);
                chk("rsp_enable_low", enable, 0);
                chk("rsp_sel_next", sel, aq.size() != 0);
            end
            busy = 0;
        end else begin
            chk("rsp_idle_zero", rsp_rdata | {30'h0, rsp_err, rsp_timeout}, 0);
        end

        if (sel && !enable) begin
            if (aq.size() == 0) chk("setup_unexpected", 1, 0);
            else begin
                cur = aq.pop_front();
                eq.push_back(cur);
                acc = 0;
                busy = 1;
                check_fields("setup");
            end
        end else if (sel && enable) begin
            if (busy) check_fields("access");
        end else begin
            chk("idle_apb_zero", addr | wdata | {27'h0, enable, write, strobe}, 0);
        end

        if (sel && enable) begin
            ready  = (acc == cur.w);
            slverr = ready ? cur.err : 1'($urandom);
            rdata  = ready ? cur.rd : $urandom;
            acc++;
        end else begin
            ready  = 1'($urandom);
            slverr = 1'($urandom);
            rdata  = $urandom;
        end

        if (cq.size() != 0) begin
            req_valid  = 1'b1;
            req_write  = cq[0].wr;
            req_addr   = cq[0].addr;
            req_wdata  = cq[0].wdata;
            req_strobe = cq[0].strb;
        end else begin
            req_valid  = 1'b0;
            req_write  = 1'($urandom);
            req_addr   = $urandom;
            req_wdata  = $urandom;
            req_strobe = 4'($urandom);
        end
        #1;
        chk("req_ready", req_ready, (sel && enable) ? (ready || acc == TO) : !sel);
        hs = req_valid && req_ready;
        @(posedge clk);
        @(negedge clk);
        if (hs) aq.push_back(cq.pop_front());
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((cq.size() != 0 || aq.size() != 0 || eq.size() != 0 || sel) && n < 200) begin
            cycle();
            n++;
        end
        chk("drain_done", n < 200, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = 1'b0; ready = 1'b0; slverr = 1'b0; rdata = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cq.delete(); aq.delete(); eq.delete();
        busy = 0;
        chk("rst_apb", addr | wdata | {27'h0, sel, enable, write, strobe}, 0);
        chk("rst_rsp", rsp_rdata | {29'h0, rsp_valid, rsp_err, rsp_timeout}, 0);
        chk("rst_req_ready", req_ready, 1);
    endtask

    initial begin
        int n;
        vec_t v;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        req_strobe = '0; ready = 1'b0; rdata = '0; slverr = 1'b0; busy = 0; acc = 0;
        do_reset();

        //          wr  addr        wdata         strb  w  err rd            chain e_rdata       e_err e_to e_acc
        tbl[0] = mk(1, 32'h10,     32'hA5A5_5A5A, 4'hF, 1, 0, 32'h0000_1234, 0, 32'h0,         0, 0, 2);
        tbl[1] = mk(0, 32'h04,     32'h0,         4'hF, 0, 0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0, 0, 1);
        tbl[2] = mk(0, 32'h400,    32'h0,         4'hF, 0, 1, 32'h0000_FFFF, 0, 32'h0,         1, 0, 1);
        tbl[3] = mk(0, 32'h0,      32'h0,         4'hF, 0, 0, 32'h0000_0011, 1, 32'h0000_0011, 0, 0, 1);
        tbl[4] = mk(0, 32'h4,      32'h0,         4'hF, 0, 0, 32'h0000_0022, 1, 32'h0000_0022, 0, 0, 1);
        tbl[5] = mk(0, 32'h8,      32'h0,         4'hF, 0, 0, 32'h0000_0033, 0, 32'h0000_0033, 0, 0, 1);
        tbl[6] = mk(1, 32'h20,     32'h1234_5678, 4'h3, 9, 0, 32'h0,         0, 32'h0,         1, 1, 4);
        tbl[7] = mk(0, 32'h24,     32'h0,         4'h1, 3, 0, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 0, 0, 4);
        tbl[8] = mk(0, 32'h28,     32'h0,         4'hC, 4, 0, 32'h5555_AAAA, 0, 32'h0,         1, 1, 4);
        tbl[9] = mk(1, 32'h2C,     32'hFFFF_0000, 4'h8, 2, 1, 32'h0,         0, 32'h0,         1, 0, 3);

        for (int i = 0; i < 10; i++) begin
            cq.push_back(tbl[i]);
            if (!tbl[i].chain) drain();
        end

        // reset in the middle of a stalled ACCESS must abort without a response
        cq.push_back(mk(0, 32'h30, 32'h0, 4'hF, 9, 0, 32'h0, 0, 32'h0, 1, 1, 4));
        n = 0;
        while (!(sel && enable) && n < 10) begin
            cycle();
            n++;
        end
        chk("reach_access", sel && enable, 1);
        cycle();
        do_reset();
        cycle();
        cq.push_back(mk(0, 32'h34, 32'h0, 4'hF, 1, 0, 32'h0BAD_CAFE, 0, 32'h0BAD_CAFE, 0, 0, 2));
        drain();

        for (int i = 0; i < 60; i++) begin
            v.wr    = 1'($urandom);
            v.addr  = $urandom;
            v.wdata = $urandom;
            v.strb  = 4'($urandom);
            v.w     = int'($urandom_range(0, 6));
            v.err   = ($urandom_range(0, 3) == 0);
            v.rd    = $urandom;
            v.chain = 1'($urandom);
            v = model(v);
            cq.push_back(v);
            if (!v.chain) drain();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/apb_master_ctrl.md
Name: apb_master_ctrl

Overview:
- APB requester stage directly upstream of the bridge's APB slave port.
- Accepts single read/write transfer requests on a valid/ready command interface and runs the APB SETUP/ACCESS protocol (sel, enable, write, addr, wdata, strobe).
- Returns a one-cycle response carrying rdata, slverr and a watchdog timeout flag.
- Supports back-to-back transfers with no intervening IDLE cycle.

Parameters:
- ADDR_WIDTH, 32, width of addr and req_addr.
- DATA_WIDTH, 32, width of wdata, rdata, req_wdata and rsp_rdata.
- STRB_WIDTH, DATA_WIDTH/8, byte-lane strobe width.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles waiting for ready before abort; legal range 2..255.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when req_valid & req_ready at a rising edge
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  transfer address
- req_wdata  in  DATA_WIDTH  write data, ignored for reads
- req_strobe  in  STRB_WIDTH  byte-lane enables
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes, errors and timeouts
- rsp_err  out  1  slverr was sampled or a timeout occurred
- rsp_timeout  out  1  transfer aborted by the watchdog
- sel  out  1  APB select
- enable  out  1  APB enable
- write  out  1  APB direction
- addr  out  ADDR_WIDTH  APB address
- wdata  out  DATA_WIDTH  APB write data
- strobe  out  STRB_WIDTH  APB strobe
- ready  in  1  APB ready from slave
- rdata  in  DATA_WIDTH  APB read data
- slverr  in  1  APB error, valid only with ready

Behaviour:
- Reset: one cycle with rst=1 at a rising edge forces state IDLE.
  - Outputs after reset: sel=0, enable=0, write=0, addr=0, wdata=0, strobe=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, timeout counter=0.
  - rst mid-transfer aborts silently: no rsp_valid is produced.
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered.
- req_ready:
  - 1 in IDLE.
  - 1 in ACCESS in the same cycle ready=1.
  - 1 in ACCESS in the cycle the timeout fires.
  - 0 otherwise.
  - Combinational from state, ready and the counter; no dependency on req_valid.
- IDLE: on a handshake, capture write/addr/wdata/strobe into the APB output registers and go to SETUP. Next cycle: sel=1, enable=0.
- SETUP: lasts exactly one cycle, then ACCESS with sel=1, enable=1. APB fields are held stable.
- ACCESS: all APB fields are held until completion. The counter increments each ACCESS cycle with ready=0.
- Completion (ready=1 in ACCESS):
  - Next cycle: rsp_valid=1 for exactly one cycle.
  - rsp_err=slverr.
  - rsp_rdata=rdata if read and slverr=0, else 0.
  - rsp_timeout=0.
  - Counter is cleared.
- Timeout: counter reaches TIMEOUT_CYCLES-1 with ready still 0.
  - Next cycle: rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - APB returns to sel=0, enable=0 (or to SETUP if a new request was accepted).
- Back-to-back: on a completion or timeout cycle with req_valid=1, the new command is captured and the FSM goes straight to SETUP.
  - Next cycle: sel=1, enable=0 with the new fields, while rsp_valid reports the previous transfer in the same cycle.
- No new request at completion: go to IDLE. sel=0, enable=0; addr/wdata/strobe/write are cleared to 0.
- strobe is driven with req_strobe for both reads and writes; the downstream slave uses strobe for its range check.
- Response fields are held at 0 whenever rsp_valid=0.
- No response backpressure: rsp_valid is a pulse and the consumer must always accept it.
- At most one transfer is outstanding. There is no internal queue.

Test Plan:
- Write: req write addr=0x10, wdata=0xA5A5_5A5A, strobe=4'hF; slave ready on 2nd ACCESS cycle → sel high 3 cycles, enable high 2 cycles, addr/wdata stable; rsp_valid pulse, rsp_err=0, rsp_rdata=0.
- Read: req read addr=0x04, strobe=4'hF; slave returns rdata=0xDEAD_BEEF with ready → rsp_rdata=0xDEAD_BEEF, rsp_err=0, exactly one rsp_valid.
- Error: read addr beyond memory; slave gives ready=1, slverr=1 → rsp_err=1, rsp_rdata=0, rsp_timeout=0.
- Back-to-back: req_valid held with 3 queued commands (addr 0x0, 0x4, 0x8) and an always-ready slave → pattern SETUP, ACCESS, SETUP, ACCESS, ... with no IDLE gap; rsp_valid coincides with the next SETUP; 3 responses in order.
- Timeout: TIMEOUT_CYCLES=4; slave never asserts ready → enable high 4 cycles, then rsp_valid=1, rsp_err=1, rsp_timeout=1; sel drops next cycle.
- Reset mid-ACCESS: assert rst for 1 cycle during ACCESS → next cycle all outputs 0, state IDLE, no rsp_valid; a subsequent request completes normally.
